// File: rtl/dac_ctrl_gen.sv
`default_nettype none
// ============================================================================
// dac_ctrl_gen : parametrised serial audio DAC controller (mclk/sclk/lrck/sdti)
// Revision     : 1.0 - initial release
// ============================================================================
module dac_ctrl_gen #(
   parameter int SAMPLE_W = 16,
   parameter int SLOT_W   = 32,
   parameter int MCLK_DIV = 4,
   parameter int SCLK_DIV = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample_l,
   input  logic [SAMPLE_W-1:0] sample_r,
   input  logic                fmt,
   input  logic                mute,
   output logic                next,
   output logic                mclk,
   output logic                sclk,
   output logic                lrck,
   output logic                sdti
);

   localparam int              FRAME    = 2 * SLOT_W * SCLK_DIV;
   localparam int              CNT_W    = $clog2(FRAME);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

   generate
      if ((MCLK_DIV < 2) || (MCLK_DIV % 2 != 0) || (SCLK_DIV % 2 != 0) ||
          (SCLK_DIV % MCLK_DIV != 0) || (SLOT_W < SAMPLE_W + 1)) begin : g_param_check
         $error("dac_ctrl_gen: illegal parameter combination");
      end
   endgenerate

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
   logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
   logic                fmt_q, fmt_d;
   logic                next_q, next_d;
   logic                mclk_q, mclk_d;
   logic                sclk_q, sclk_d;
   logic                lrck_q, lrck_d;
   logic                sdti_q, sdti_d;

   logic                frame_end;
   int                  t;
   int                  bit_idx;
   int                  pos;
   int                  d;
   logic [SAMPLE_W-1:0] word;
   logic [SAMPLE_W-1:0] shifted;

   // Pins are registered from the next count so they line up with cnt_q.
   always_comb begin
      frame_end = (cnt_q == CNT_LAST);
      cnt_d     = frame_end ? '0 : cnt_q + CNT_W'(1);
      hold_l_d  = hold_l_q;
      hold_r_d  = hold_r_q;
      fmt_d     = fmt_q;
      if (frame_end) begin
         hold_l_d = mute ? '0 : sample_l;
         hold_r_d = mute ? '0 : sample_r;
         fmt_d    = fmt;
      end

      t       = int'(cnt_d);
      next_d  = (cnt_d == CNT_LAST);
      mclk_d  = (t % MCLK_DIV) >= (MCLK_DIV / 2);
      sclk_d  = (t % SCLK_DIV) >= (SCLK_DIV / 2);
      bit_idx = t / SCLK_DIV;
      lrck_d  = (bit_idx >= SLOT_W);
      pos     = bit_idx % SLOT_W;
      d       = fmt_d ? pos : pos - 1;
      word    = lrck_d ? hold_r_d : hold_l_d;
      shifted = word >> (SAMPLE_W - 1 - d);
      sdti_d  = 1'b0;
      if ((d >= 0) && (d < SAMPLE_W)) begin
         sdti_d = shifted[0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         hold_l_q <= '0;
         hold_r_q <= '0;
         fmt_q    <= 1'b0;
         next_q   <= 1'b0;
         mclk_q   <= 1'b0;
         sclk_q   <= 1'b0;
         lrck_q   <= 1'b0;
         sdti_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         hold_l_q <= hold_l_d;
         hold_r_q <= hold_r_d;
         fmt_q    <= fmt_d;
         next_q   <= next_d;
         mclk_q   <= mclk_d;
         sclk_q   <= sclk_d;
         lrck_q   <= lrck_d;
         sdti_q   <= sdti_d;
      end
   end

   assign next = next_q;
   assign mclk = mclk_q;
   assign sclk = sclk_q;
   assign lrck = lrck_q;
   assign sdti = sdti_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_ctrl_gen.sv
`default_nettype none
// ============================================================================
// tb_dac_ctrl_gen : directed scoreboard bench for dac_ctrl_gen (two configs)
// Revision        : 1.0 - initial release
// ============================================================================
module tb_dac_ctrl_gen;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [63:0] sb_q[$];

   // Default configuration
   logic        reset_a, fmt_a, mute_a;
   logic [15:0] sl_a, sr_a;
   logic        next_a, mclk_a, sclk_a, lrck_a, sdti_a;

   // 24-bit configuration
   logic        reset_b, fmt_b, mute_b;
   logic [23:0] sl_b, sr_b;
   logic        next_b, mclk_b, sclk_b, lrck_b, sdti_b;

   dac_ctrl_gen dut_a (
      .clk(clk), .reset(reset_a), .sample_l(sl_a), .sample_r(sr_a),
      .fmt(fmt_a), .mute(mute_a), .next(next_a), .mclk(mclk_a),
      .sclk(sclk_a), .lrck(lrck_a), .sdti(sdti_a)
   );

   dac_ctrl_gen #(.SAMPLE_W(24), .SLOT_W(32), .MCLK_DIV(2), .SCLK_DIV(8)) dut_b (
      .clk(clk), .reset(reset_b), .sample_l(sl_b), .sample_r(sr_b),
      .fmt(fmt_b), .mute(mute_b), .next(next_b), .mclk(mclk_b),
      .sclk(sclk_b), .lrck(lrck_b), .sdti(sdti_b)
   );

   function automatic logic [4:0] pins(input bit which);
      return which ? {next_b, mclk_b, sclk_b, lrck_b, sdti_b}
                   : {next_a, mclk_a, sclk_a, lrck_a, sdti_a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected slot contents, position 0 of the left slot at bit 63.
   task automatic push_exp(input bit which);
      logic [63:0] e;
      if (!which) begin
         if (mute_a)     e = '0;
         else if (fmt_a) e = {sl_a, 16'h0, sr_a, 16'h0};
         else            e = {1'b0, sl_a, 15'h0, 1'b0, sr_a, 15'h0};
      end else begin
         if (mute_b)     e = '0;
         else if (fmt_b) e = {sl_b, 8'h0, sr_b, 8'h0};
         else            e = {1'b0, sl_b, 7'h0, 1'b0, sr_b, 7'h0};
      end
      sb_q.push_back(e);
   endtask

   // Walks one frame cycle by cycle; returns while in the t = F-1 cycle.
   task automatic recv_frame(input string tag, input bit which, input bit skip_first,
                             input bit mid_en, input logic mid_fmt, input logic mid_mute,
                             input logic [15:0] mid_l);
      int          fr, sd, md;
      int          pin_errs, stab_errs;
      logic [63:0] rx;
      logic [4:0]  p, ep;
      logic        cur;
      fr        = which ? 512 : 1024;
      sd        = which ? 8 : 16;
      md        = which ? 2 : 4;
      pin_errs  = 0;
      stab_errs = 0;
      rx        = '0;
      cur       = 1'b0;
      for (int t = 0; t < fr; t++) begin
         if ((t > 0) || !skip_first) begin
            @(posedge clk);
            #1;
         end
         p     = pins(which);
         ep    = '0;
         ep[4] = (t == fr - 1);
         ep[3] = (t % md) >= (md / 2);
         ep[2] = (t % sd) >= (sd / 2);
         ep[1] = (t / sd) >= 32;
         if (p[4:1] !== ep[4:1]) pin_errs++;
         if (t % sd == 0) cur = p[0];
         else if (p[0] !== cur) stab_errs++;
         if (t % sd == sd / 2) rx = {rx[62:0], p[0]};
         if (mid_en && (t == fr / 2)) begin
            fmt_a  = mid_fmt;
            mute_a = mid_mute;
            sl_a   = mid_l;
         end
      end
      chk({tag, " pins"}, 64'(pin_errs), 64'd0);
      chk({tag, " sdti_stable"}, 64'(stab_errs), 64'd0);
      chk({tag, " sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) chk({tag, " data"}, rx, sb_q.pop_front());
   endtask

   initial begin
      reset_a = 1'b1; fmt_a = 1'b0; mute_a = 1'b0; sl_a = '0; sr_a = '0;
      reset_b = 1'b1; fmt_b = 1'b0; mute_b = 1'b0; sl_b = '0; sr_b = '0;

      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk("reset_pins_a", 64'(pins(1'b0)), 64'd0);
      end
      chk("reset_pins_b", 64'(pins(1'b1)), 64'd0);

      // Frame 0 after release is silent; the I2S samples land in frame 1.
      sb_q.push_back('0);
      sl_a = 16'h0FF0; sr_a = 16'hAA55; fmt_a = 1'b0; mute_a = 1'b0;
      reset_a = 1'b0;
      recv_frame("a_f0_zero", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      push_exp(1'b0);
      recv_frame("a_f1_i2s", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0FF0);
      push_exp(1'b0);
      recv_frame("a_f2_lj", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0FF0);
      push_exp(1'b0);
      recv_frame("a_f3_mute_on", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7FFF);
      push_exp(1'b0);
      recv_frame("a_f4_muted", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF);
      push_exp(1'b0);
      recv_frame("a_f5_unmuted", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

      // Mid-frame reset at t = 300, where sclk is high.
      for (int t = 0; t <= 300; t++) begin
         @(posedge clk);
         #1;
      end
      chk("pre_reset_sclk", 64'(sclk_a), 64'd1);
      reset_a = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_reset_pins", 64'(pins(1'b0)), 64'd0);
      sb_q.push_back('0);
      reset_a = 1'b0;
      recv_frame("a_post_reset_zero", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      push_exp(1'b0);
      recv_frame("a_post_reset_data", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

      // 24-bit samples in 32-bit slots, F = 512.
      sl_b = 24'h800001; sr_b = 24'h5A0F3C; fmt_b = 1'b0; mute_b = 1'b0;
      sb_q.push_back('0);
      reset_b = 1'b0;
      recv_frame("b_f0_zero", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      push_exp(1'b1);
      recv_frame("b_f1_i2s", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
